// File: rtl/rsa_session_ctrl.sv
// Session controller for one RSA run: host byte load, CPU run window, result readout.
// Owns the data-memory port mux between the host load path, the CPU and the readout path.
`timescale 1ns/1ps
module rsa_session_ctrl #(
  parameter logic [31:0] LOAD_BASE   = 32'h0000_0000,
  parameter int unsigned LOAD_WORDS  = 16,
  parameter logic [31:0] RES_BASE    = 32'h0000_0100,
  parameter int unsigned RES_WORDS   = 16,
  parameter int unsigned RUN_TIMEOUT = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_start,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [7:0]  i_in_data,
  output logic        o_cpu_reset,
  output logic        o_cpu_start,
  input  logic        i_cpu_end,
  input  logic        i_cpu_mem_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [7:0]  o_out_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int unsigned IW = $clog2(LOAD_WORDS) + 1;
  localparam int unsigned KW = $clog2(RES_WORDS) + 1;
  localparam int unsigned TW = $clog2(RUN_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN_START, S_RUN, S_RD_ADDR, S_RD_CAP, S_OUT, S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_i;
  logic [KW-1:0]   r_k;
  logic [TW-1:0]   r_timer;
  logic            r_in_ready, r_cpu_reset, r_cpu_start, r_out_valid;
  logic            r_busy, r_done, r_err;
  logic [7:0]      r_out_data;

  logic            w_last_load, w_last_res, w_timeout, w_out_hs;
  logic [31:0]     w_load_addr, w_res_addr;
  logic            w_unused_rdata;

  assign w_last_load    = (r_i == IW'(LOAD_WORDS - 1));
  assign w_last_res     = (r_k == KW'(RES_WORDS - 1));
  assign w_timeout      = (r_timer == TW'(RUN_TIMEOUT - 1));
  assign w_out_hs       = (r_state == S_OUT) && i_out_ready;
  assign w_load_addr    = LOAD_BASE + (32'(r_i) << 2);
  assign w_res_addr     = RES_BASE + (32'(r_k) << 2);
  assign w_unused_rdata = ^i_mem_rdata[31:8];

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next state plus the combinational memory-port mux; CPU only reaches memory in RUN.
  always_comb begin
    w_next      = r_state;
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    case (r_state)
      S_IDLE: if (i_cmd_start) w_next = S_LOAD;
      S_LOAD: begin
        if (i_in_valid) begin
          o_mem_we    = 1'b1;
          o_mem_addr  = w_load_addr;
          o_mem_wdata = {24'h0, i_in_data};
          if (w_last_load) w_next = S_RUN_START;
        end
      end
      S_RUN_START: w_next = S_RUN;
      S_RUN: begin
        o_mem_we    = i_cpu_mem_we;
        o_mem_addr  = i_cpu_addr;
        o_mem_wdata = i_cpu_wdata;
        if (i_cpu_end)      w_next = S_RD_ADDR;
        else if (w_timeout) w_next = S_DONE;
      end
      S_RD_ADDR: begin
        o_mem_addr = w_res_addr;
        w_next     = S_RD_CAP;
      end
      S_RD_CAP: begin
        o_mem_addr = w_res_addr;
        w_next     = S_OUT;
      end
      S_OUT: begin
        o_mem_addr = w_res_addr;
        if (w_out_hs) w_next = w_last_res ? S_DONE : S_RD_ADDR;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_in_ready  <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_cpu_start <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_out_data  <= 8'h0;
      r_i         <= '0;
      r_k         <= '0;
      r_timer     <= '0;
    end else begin
      r_in_ready  <= (w_next == S_LOAD);
      r_cpu_reset <= !((w_next == S_RUN_START) || (w_next == S_RUN));
      r_cpu_start <= (w_next == S_RUN_START);
      r_out_valid <= (w_next == S_OUT);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_cmd_start) begin
            r_err <= 1'b0;
            r_i   <= '0;
          end
        end
        S_LOAD:      if (i_in_valid) r_i <= r_i + IW'(1);
        S_RUN_START: r_timer <= '0;
        S_RUN: begin
          r_timer <= r_timer + TW'(1);
          if (i_cpu_end)      r_k   <= '0;
          else if (w_timeout) r_err <= 1'b1;
        end
        S_RD_CAP: r_out_data <= i_mem_rdata[7:0];
        S_OUT:    if (w_out_hs) r_k <= r_k + KW'(1);
        default: ;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_cpu_reset = r_cpu_reset;
  assign o_cpu_start = r_cpu_start;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
